// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: owner and debug-handshake encodings
// plus the owner priority rule.
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      OWN_NONE = 2'd0,
      OWN_CPU  = 2'd1,
      OWN_DBG  = 2'd2
   } owner_e;

   typedef enum logic {
      D_IDLE = 1'b0,
      D_ACK  = 1'b1
   } dbg_state_e;

   localparam int STALL_W = 16;

   // A starved debug request beats the CPU; otherwise the CPU has priority.
   function automatic owner_e select_owner(input logic cpu_req,
                                           input logic dbg_avail,
                                           input logic dbg_starved);
      owner_e o;
      if (dbg_avail && dbg_starved) begin
         o = OWN_DBG;
      end else if (cpu_req) begin
         o = OWN_CPU;
      end else if (dbg_avail) begin
         o = OWN_DBG;
      end else begin
         o = OWN_NONE;
      end
      return o;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module sat_counter #(
   parameter int              WIDTH = 8,
   parameter logic [WIDTH-1:0] MAX  = {WIDTH{1'b1}}
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] q_r;

   // Count register: holds at MAX instead of wrapping.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         q_r <= '0;
      end else if (clr) begin
         q_r <= '0;
      end else if (inc && (q_r != MAX)) begin
         q_r <= q_r + WIDTH'(1);
      end else begin
         q_r <= q_r;
      end
   end

   assign q = q_r;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port data memory between the CPU control path and the debug loader,
// one access slot per clock, with a bounded-wait guarantee for debug.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int AW       = 8,
   parameter int DW       = 8,
   parameter int MAX_WAIT = 4
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 cpu_rd,
   input  logic                 cpu_wr,
   input  logic [AW-1:0]        cpu_addr,
   input  logic [DW-1:0]        cpu_wdata,
   output logic [DW-1:0]        cpu_rdata,
   output logic                 cpu_stall,
   input  logic                 dbg_req,
   input  logic                 dbg_we,
   input  logic [AW-1:0]        dbg_addr,
   input  logic [DW-1:0]        dbg_wdata,
   output logic                 dbg_ack,
   output logic [DW-1:0]        dbg_rdata,
   output logic                 mem_rden,
   output logic                 mem_wren,
   output logic [AW-1:0]        mem_addr,
   output logic [DW-1:0]        mem_data,
   input  logic [DW-1:0]        mem_q,
   output logic [STALL_W-1:0]   stall_cnt
);

   localparam int            WW       = $clog2(MAX_WAIT + 1);
   localparam logic [WW-1:0] WAIT_LIM = WW'(MAX_WAIT);

   owner_e             owner_s;
   owner_e             last_owner_r;
   dbg_state_e         dbg_state_r;
   logic [WW-1:0]      wait_cnt_s;
   logic               cpu_req_s;
   logic               dbg_avail_s;
   logic               dbg_grant_s;
   logic               cpu_stall_s;
   logic               wait_inc_s;
   logic               wait_clr_s;
   logic               mem_rden_s;
   logic               mem_wren_s;
   logic [AW-1:0]      mem_addr_s;
   logic [DW-1:0]      mem_data_s;
   logic [DW-1:0]      hold_r;

   assign cpu_req_s   = cpu_rd | cpu_wr;
   assign dbg_avail_s = dbg_req & (dbg_state_r == D_IDLE);

   // Owner selection; forced to NONE while reset is asserted so the port is quiet.
   always_comb begin
      owner_s = OWN_NONE;
      if (reset) begin
         owner_s = OWN_NONE;
      end else begin
         owner_s = select_owner(cpu_req_s, dbg_avail_s, wait_cnt_s == WAIT_LIM);
      end
   end

   assign dbg_grant_s = (owner_s == OWN_DBG);

   // Memory port mux driven by the current owner.
   always_comb begin
      mem_rden_s = 1'b0;
      mem_wren_s = 1'b0;
      mem_addr_s = '0;
      mem_data_s = '0;
      case (owner_s)
         OWN_CPU: begin
            mem_rden_s = cpu_rd;
            mem_wren_s = cpu_wr;
            mem_addr_s = cpu_addr;
            mem_data_s = cpu_wdata;
         end
         OWN_DBG: begin
            mem_rden_s = ~dbg_we;
            mem_wren_s = dbg_we;
            mem_addr_s = dbg_addr;
            mem_data_s = dbg_wdata;
         end
         OWN_NONE: begin
            mem_rden_s = 1'b0;
            mem_wren_s = 1'b0;
            mem_addr_s = '0;
            mem_data_s = '0;
         end
         default: begin
            mem_rden_s = 1'b0;
            mem_wren_s = 1'b0;
            mem_addr_s = '0;
            mem_data_s = '0;
         end
      endcase
   end

   // CPU stall whenever it asks for the port and someone else holds it.
   always_comb begin
      cpu_stall_s = 1'b0;
      if (reset) begin
         cpu_stall_s = 1'b0;
      end else begin
         cpu_stall_s = cpu_req_s & (owner_s != OWN_CPU);
      end
   end

   // Debug handshake FSM: one ack cycle per grant, during which debug cannot be re-granted.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         dbg_state_r <= D_IDLE;
      end else begin
         case (dbg_state_r)
            D_IDLE: begin
               if (dbg_grant_s) begin
                  dbg_state_r <= D_ACK;
               end else begin
                  dbg_state_r <= D_IDLE;
               end
            end
            D_ACK:   dbg_state_r <= D_IDLE;
            default: dbg_state_r <= D_IDLE;
         endcase
      end
   end

   // Remember who used the port so the 1-cycle-late mem_q is steered to the right reader.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         last_owner_r <= OWN_NONE;
         hold_r       <= '0;
      end else begin
         last_owner_r <= owner_s;
         if (last_owner_r == OWN_CPU) begin
            hold_r <= mem_q;
         end else begin
            hold_r <= hold_r;
         end
      end
   end

   assign wait_inc_s = dbg_avail_s & ~dbg_grant_s;
   assign wait_clr_s = dbg_grant_s | ~dbg_req;

   sat_counter #(
      .WIDTH (WW),
      .MAX   (WAIT_LIM)
   ) u_wait_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (wait_inc_s),
      .clr   (wait_clr_s),
      .q     (wait_cnt_s)
   );

   sat_counter #(
      .WIDTH (STALL_W),
      .MAX   (16'hFFFF)
   ) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (cpu_stall_s),
      .clr   (1'b0),
      .q     (stall_cnt)
   );

   assign cpu_stall = cpu_stall_s;
   assign mem_rden  = mem_rden_s;
   assign mem_wren  = mem_wren_s;
   assign mem_addr  = mem_addr_s;
   assign mem_data  = mem_data_s;
   assign dbg_ack   = (dbg_state_r == D_ACK);
   assign dbg_rdata = (dbg_state_r == D_ACK) ? mem_q : '0;
   assign cpu_rdata = (last_owner_r == OWN_CPU) ? mem_q : hold_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: vector table, hand-written corner sequences and a randomized
// run against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

   localparam int MAX_WAIT = 4;

   logic        clock = 1'b0;
   logic        reset;
   logic        tb_init;
   logic        cpu_rd, cpu_wr, dbg_req, dbg_we;
   logic [7:0]  cpu_addr, cpu_wdata, dbg_addr, dbg_wdata;
   logic [7:0]  cpu_rdata, dbg_rdata, mem_addr, mem_data, mem_q;
   logic        cpu_stall, dbg_ack, mem_rden, mem_wren;
   logic [15:0] stall_cnt;
   logic        sat_inc, sat_clr;
   logic [2:0]  sat_q;

   int tests;
   int failed;

   mem_port_arbiter #(.AW(8), .DW(8), .MAX_WAIT(MAX_WAIT)) dut (
      .clock(clock), .reset(reset),
      .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_ack(dbg_ack), .dbg_rdata(dbg_rdata),
      .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_data(mem_data),
      .mem_q(mem_q), .stall_cnt(stall_cnt)
   );

   sat_counter #(.WIDTH(3), .MAX(3'd5)) u_sat (
      .clock(clock), .reset(reset), .inc(sat_inc), .clr(sat_clr), .q(sat_q)
   );

   always #5 clock = ~clock;

   function automatic logic [7:0] init_val(input int i);
      if (i == 16) return 8'hA5;
      if (i == 17) return 8'h5A;
      return 8'(i * 3 + 1);
   endfunction

   // Memory with registered read data.
   logic [7:0] tmem [256];
   always @(posedge clock) begin
      if (tb_init) begin
         for (int i = 0; i < 256; i++) tmem[i] <= init_val(i);
         mem_q <= 8'h00;
      end else begin
         if (mem_wren) tmem[mem_addr] <= mem_data;
         if (mem_rden) mem_q <= tmem[mem_addr];
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic idle_inputs();
      cpu_rd = 1'b0; cpu_wr = 1'b0; cpu_addr = 8'h00; cpu_wdata = 8'h00;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 8'h00; dbg_wdata = 8'h00;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset = 1'b1; tb_init = 1'b1;
      idle_inputs();
      repeat (2) @(negedge clock);
      reset = 1'b0; tb_init = 1'b0;
   endtask

   typedef struct {
      logic cpu_rd; logic cpu_wr; logic [7:0] cpu_addr; logic [7:0] cpu_wdata;
      logic dbg_req; logic dbg_we; logic [7:0] dbg_addr; logic [7:0] dbg_wdata;
      logic e_rden; logic e_wren; logic [7:0] e_addr; logic [7:0] e_data;
      logic e_stall; logic e_ack;
      logic chk_cpu; logic [7:0] e_cpu; logic chk_dbg; logic [7:0] e_dbg;
   } vec_t;
   vec_t vecs [11];

   // Reference model state (transaction level).
   logic [7:0] ref_mem [256];
   int         losses;
   int         m_stalls;
   bit         ackp, ack_rd, cpu_rl;
   logic [7:0] m_dbg, m_cpu;
   bit         creq, forced, g_dbg, g_cpu;
   logic [17:0] exp_port;
   int         grant_cyc, acc, ak, k;

   initial begin
      tests = 0; failed = 0;
      sat_inc = 1'b0; sat_clr = 1'b0;
      reset = 1'b1; tb_init = 1'b1;
      idle_inputs();
      cpu_rd = 1'b1; cpu_addr = 8'h10; dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h20;
      #2;
      check("reset_outputs", {mem_rden, mem_wren, mem_addr, mem_data, cpu_stall, dbg_ack,
                              cpu_rdata, dbg_rdata}, 32'h0);
      check("reset_stall_cnt", {16'h0, stall_cnt}, 32'h0);

      //             cpu rd wr addr  wdata  dbg req we addr  wdata  rden wren addr  data  stl ack  chkc ecpu  chkd edbg
      vecs[0]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'h00};
      vecs[1]  = '{1'b1,1'b0,8'h10,8'hEE, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h10,8'hEE,1'b0,1'b0, 1'b0,8'h00,1'b0,8'h00};
      vecs[2]  = '{1'b0,1'b1,8'h30,8'h77, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b1,8'h30,8'h77,1'b0,1'b0, 1'b1,8'hA5,1'b0,8'h00};
      vecs[3]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h3C, 1'b0,1'b1,8'h20,8'h3C,1'b0,1'b0, 1'b0,8'h00,1'b0,8'h00};
      vecs[4]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b1,8'h20,8'h3C, 1'b0,1'b0,8'h00,8'h00,1'b0,1'b1, 1'b0,8'h00,1'b0,8'h00};
      vecs[5]  = '{1'b1,1'b0,8'h20,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'h00};
      vecs[6]  = '{1'b1,1'b0,8'h10,8'h01, 1'b1,1'b0,8'h20,8'h99, 1'b1,1'b0,8'h10,8'h01,1'b0,1'b0, 1'b1,8'h3C,1'b0,8'h00};
      vecs[7]  = '{1'b0,1'b0,8'h00,8'h00, 1'b1,1'b0,8'h20,8'h99, 1'b1,1'b0,8'h20,8'h99,1'b0,1'b0, 1'b1,8'hA5,1'b0,8'h00};
      vecs[8]  = '{1'b0,1'b1,8'h31,8'h11, 1'b1,1'b0,8'h20,8'h99, 1'b0,1'b1,8'h31,8'h11,1'b0,1'b1, 1'b1,8'hA5,1'b1,8'h3C};
      vecs[9]  = '{1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00, 1'b0,1'b0,8'h00,8'h00,1'b0,1'b0, 1'b1,8'h3C,1'b0,8'h00};
      vecs[10] = '{1'b1,1'b0,8'h10,8'h00, 1'b1,1'b1,8'h21,8'h42, 1'b1,1'b0,8'h10,8'h00,1'b0,1'b0, 1'b0,8'h00,1'b0,8'h00};

      do_reset();
      for (int v = 0; v < 11; v++) begin
         @(negedge clock);
         cpu_rd = vecs[v].cpu_rd; cpu_wr = vecs[v].cpu_wr;
         cpu_addr = vecs[v].cpu_addr; cpu_wdata = vecs[v].cpu_wdata;
         dbg_req = vecs[v].dbg_req; dbg_we = vecs[v].dbg_we;
         dbg_addr = vecs[v].dbg_addr; dbg_wdata = vecs[v].dbg_wdata;
         #1;
         check($sformatf("vec%0d_port", v),
               {mem_rden, mem_wren, mem_addr, mem_data, cpu_stall, dbg_ack},
               {vecs[v].e_rden, vecs[v].e_wren, vecs[v].e_addr, vecs[v].e_data,
                vecs[v].e_stall, vecs[v].e_ack});
         if (vecs[v].chk_cpu) check($sformatf("vec%0d_cpu_rdata", v), cpu_rdata, vecs[v].e_cpu);
         if (vecs[v].chk_dbg) check($sformatf("vec%0d_dbg_rdata", v), dbg_rdata, vecs[v].e_dbg);
      end

      // Starvation: CPU reads 0x10 every cycle, debug read of 0x11 held.
      do_reset();
      grant_cyc = 0;
      for (int cyc = 1; cyc <= 10 && grant_cyc == 0; cyc++) begin
         @(negedge clock);
         cpu_rd = 1'b1; cpu_wr = 1'b0; cpu_addr = 8'h10;
         dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h11;
         #1;
         if (cpu_stall) begin
            grant_cyc = cyc;
            check("starve_grant_port", {mem_rden, mem_wren, mem_addr}, {1'b1, 1'b0, 8'h11});
            check("starve_cpu_rdata", cpu_rdata, 8'hA5);
         end
      end
      check("starve_grant_cycle", grant_cyc, 5);
      @(negedge clock);
      dbg_req = 1'b0;
      #1;
      check("starve_ack", {dbg_ack, cpu_stall, mem_rden, mem_addr}, {1'b1, 1'b0, 1'b1, 8'h10});
      check("hold_dbg_rdata", dbg_rdata, 8'h5A);
      check("hold_cpu_rdata", cpu_rdata, 8'hA5);
      @(negedge clock);
      cpu_rd = 1'b0;
      #1;
      check("starve_stall_cnt", {16'h0, stall_cnt}, 32'd1);
      check("starve_ack_once", dbg_ack, 1'b0);

      // Reset in the middle of a debug write's ack cycle.
      @(negedge clock);
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 8'h40; dbg_wdata = 8'h66;
      #1;
      check("rst_pre_grant", {mem_wren, mem_addr}, {1'b1, 8'h40});
      @(posedge clock);
      #2;
      reset = 1'b1; cpu_rd = 1'b1; cpu_addr = 8'h10;
      #1;
      check("rst_mid_outputs", {mem_rden, mem_wren, mem_addr, mem_data, cpu_stall, dbg_ack,
                                cpu_rdata, dbg_rdata}, 32'h0);
      check("rst_mid_stall_cnt", {16'h0, stall_cnt}, 32'h0);
      repeat (2) @(negedge clock);
      reset = 1'b0; idle_inputs();
      ak = 0;
      repeat (4) begin
         @(posedge clock);
         #1;
         ak += int'(dbg_ack);
      end
      check("rst_no_ack_after", ak, 0);

      // Request held high continuously: one access per ack.
      do_reset();
      acc = 0; ak = 0;
      for (int cyc = 0; cyc < 12; cyc++) begin
         @(negedge clock);
         dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 8'h12;
         #1;
         acc += int'(mem_rden | mem_wren);
         ak  += int'(dbg_ack);
      end
      check("dbl_accesses", acc, 6);
      check("dbl_acks", ak, 6);
      dbg_req = 1'b0;

      // Saturating counter boundary.
      @(negedge clock);
      sat_inc = 1'b1;
      repeat (3) @(negedge clock);
      #1 check("sat_count3", sat_q, 3'd3);
      repeat (5) @(negedge clock);
      #1 check("sat_hold_max", sat_q, 3'd5);
      sat_clr = 1'b1;
      @(negedge clock);
      #1 check("sat_clr_wins", sat_q, 3'd0);
      sat_inc = 1'b0; sat_clr = 1'b0;

      // Randomized run against the model.
      do_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
      losses = 0; m_stalls = 0; ackp = 0; ack_rd = 0; cpu_rl = 0; m_dbg = 8'h00; m_cpu = 8'h00;
      for (int c = 0; c < 1500; c++) begin
         @(negedge clock);
         k = $urandom_range(0, 3);
         cpu_rd = (k == 1) || (k == 3); cpu_wr = (k == 2);
         cpu_addr = 8'($urandom_range(0, 255)); cpu_wdata = 8'($urandom);
         if (!dbg_req || ackp) begin
            if ($urandom_range(0, 2) == 0) begin
               dbg_req = 1'b1; dbg_we = 1'($urandom_range(0, 1));
               dbg_addr = 8'($urandom_range(0, 255)); dbg_wdata = 8'($urandom);
            end else begin
               dbg_req = 1'b0;
            end
         end
         #1;
         creq   = cpu_rd | cpu_wr;
         forced = dbg_req && !ackp && (losses >= MAX_WAIT);
         g_dbg  = forced || (!creq && dbg_req && !ackp);
         g_cpu  = creq && !forced;
         if (g_cpu)      exp_port = {cpu_rd, cpu_wr, cpu_addr, cpu_wdata};
         else if (g_dbg) exp_port = {!dbg_we, dbg_we, dbg_addr, dbg_wdata};
         else            exp_port = 18'h0;
         check("rand_port", {mem_rden, mem_wren, mem_addr, mem_data}, exp_port);
         check("rand_stall_ack", {cpu_stall, dbg_ack}, {creq && !g_cpu, ackp});
         check("rand_stall_cnt", {16'h0, stall_cnt}, m_stalls);
         if (ackp && ack_rd) check("rand_dbg_rdata", dbg_rdata, m_dbg);
         if (cpu_rl) check("rand_cpu_rdata", cpu_rdata, m_cpu);
         if (g_dbg) begin
            if (dbg_we) ref_mem[dbg_addr] = dbg_wdata;
            else        m_dbg = ref_mem[dbg_addr];
         end
         if (g_cpu) begin
            if (cpu_wr) ref_mem[cpu_addr] = cpu_wdata;
            if (cpu_rd) m_cpu = ref_mem[cpu_addr];
         end
         cpu_rl = g_cpu && cpu_rd;
         ack_rd = g_dbg && !dbg_we;
         if (g_dbg || !dbg_req) losses = 0;
         else if (!ackp)        losses = (losses + 1 > MAX_WAIT) ? MAX_WAIT : losses + 1;
         ackp = g_dbg;
         if (creq && !g_cpu && m_stalls < 65535) m_stalls++;
      end
      @(negedge clock);
      idle_inputs();
      #1 check("rand_final_stall_cnt", {16'h0, stall_cnt}, m_stalls);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
